// File: rtl/ct_mat_pkg.sv
// Shared types and constants for the matrix completion path.
package ct_mat_pkg;

    localparam int IID_W       = 7;
    localparam int NUM_MAT_SRC = 3;

    typedef enum logic [1:0] {
        MAT_SRC_CFG = 2'd0,
        MAT_SRC_ALU = 2'd1,
        MAT_SRC_LSU = 2'd2
    } mat_src_e;

    // (base + inc) mod 3 for source indices in 0..2
    function automatic logic [1:0] src_add(input logic [1:0] base, input logic [1:0] inc);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, inc};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/ct_mat_cmplt_fifo.sv
// Per-source completion FIFO; entry written at the push edge is at the head next cycle.
// Push while full or during flush is dropped; the caller watches full.
module ct_mat_cmplt_fifo #(
    parameter int IID_W = 7,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             gclk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [IID_W-1:0] push_iid,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [IID_W-1:0] head_iid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IID_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full & ~flush;
    assign pop_ok   = pop & ~empty & ~flush;
    assign head_iid = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage only toggles when the gate is open; pointers stay on the free-running clock
    always_ff @(posedge gclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_iid;
        end
    end

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: enable captured while clk_in is low, so clk_out never glitches.
// Combinational path only; no backpressure.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    output logic clk_out
);

    logic clk_en;
    logic en_lat;

    // module_en forces the clock on; external_en is the scan override
    assign clk_en = (global_en & (module_en | local_en)) | external_en;

    always_latch begin
        if (!clk_in) begin
            en_lat <= clk_en;
        end
    end

    assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/ct_mat_cmplt_arbiter.sv
// Round-robin merge of cfg/alu/lsu completions onto pipe8; one cycle from sel to cmplt minimum.
// Each source stalls on its full flag; flush kills the output and empties every FIFO.
module ct_mat_cmplt_arbiter #(
    parameter int IID_W = ct_mat_pkg::IID_W,
    parameter int DEPTH = 2
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             cp0_mat_icg_en,
    input  logic             cp0_yy_clk_en,
    input  logic             pad_yy_icg_scan_en,
    input  logic             rtu_yy_xx_flush,
    input  logic             mat_cfg_cbus_ex1_pipe8_sel,
    input  logic [IID_W-1:0] mat_cfg_cbus_ex1_pipe8_iid,
    input  logic             mat_alu_cbus_ex1_pipe8_sel,
    input  logic [IID_W-1:0] mat_alu_cbus_ex1_pipe8_iid,
    input  logic             mat_lsu_cbus_ex1_pipe8_sel,
    input  logic [IID_W-1:0] mat_lsu_cbus_ex1_pipe8_iid,
    output logic             mat_cfg_cmplt_full,
    output logic             mat_alu_cmplt_full,
    output logic             mat_lsu_cmplt_full,
    output logic             mat_rtu_pipe8_cmplt,
    output logic [IID_W-1:0] mat_rtu_pipe8_iid,
    output logic             mat_cmplt_arb_idle,
    output logic             mat_cmplt_ovf_err
);

    import ct_mat_pkg::*;

    logic [NUM_MAT_SRC-1:0] sel;
    logic [NUM_MAT_SRC-1:0] full;
    logic [NUM_MAT_SRC-1:0] empty;
    logic [NUM_MAT_SRC-1:0] pop;
    logic [IID_W-1:0]       push_iid [NUM_MAT_SRC];
    logic [IID_W-1:0]       head_iid [NUM_MAT_SRC];
    logic [1:0]             rr_ptr;
    logic [1:0]             gnt_idx;
    logic                   gnt_vld;
    logic                   local_en;
    logic                   gclk;

    assign sel = {mat_lsu_cbus_ex1_pipe8_sel, mat_alu_cbus_ex1_pipe8_sel, mat_cfg_cbus_ex1_pipe8_sel};
    assign push_iid[MAT_SRC_CFG] = mat_cfg_cbus_ex1_pipe8_iid;
    assign push_iid[MAT_SRC_ALU] = mat_alu_cbus_ex1_pipe8_iid;
    assign push_iid[MAT_SRC_LSU] = mat_lsu_cbus_ex1_pipe8_iid;

    assign mat_cfg_cmplt_full = full[MAT_SRC_CFG];
    assign mat_alu_cmplt_full = full[MAT_SRC_ALU];
    assign mat_lsu_cmplt_full = full[MAT_SRC_LSU];
    assign mat_cmplt_arb_idle = &empty;

    assign local_en = (|sel) | ~mat_cmplt_arb_idle | rtu_yy_xx_flush;

    gated_clk_cell u_icg (
        .clk_in      (forever_cpuclk),
        .global_en   (cp0_yy_clk_en),
        .module_en   (cp0_mat_icg_en),
        .local_en    (local_en),
        .external_en (pad_yy_icg_scan_en),
        .clk_out     (gclk)
    );

    for (genvar s = 0; s < NUM_MAT_SRC; s++) begin : g_fifo
        ct_mat_cmplt_fifo #(.IID_W(IID_W), .DEPTH(DEPTH)) u_fifo (
            .clk      (forever_cpuclk),
            .gclk     (gclk),
            .rst_n    (cpurst_b),
            .push     (sel[s]),
            .push_iid (push_iid[s]),
            .pop      (pop[s]),
            .flush    (rtu_yy_xx_flush),
            .full     (full[s]),
            .empty    (empty[s]),
            .head_iid (head_iid[s])
        );
    end

    // First non-empty head starting from rr_ptr wins
    always_comb begin
        logic [1:0] cand;
        cand    = '0;
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr;
        for (int k = 0; k < NUM_MAT_SRC; k++) begin
            cand = src_add(rr_ptr, 2'(k));
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign mat_rtu_pipe8_cmplt = gnt_vld & ~rtu_yy_xx_flush;
    assign mat_rtu_pipe8_iid   = mat_rtu_pipe8_cmplt ? head_iid[gnt_idx] : '0;

    always_comb begin
        pop = '0;
        if (mat_rtu_pipe8_cmplt) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rr_ptr            <= 2'd0;
            mat_cmplt_ovf_err <= 1'b0;
        end else begin
            if (mat_rtu_pipe8_cmplt) begin
                rr_ptr <= src_add(gnt_idx, 2'd1);
            end
            if (|(sel & full)) begin
                mat_cmplt_ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ct_mat_cmplt_arbiter.sv
// Bench for ct_mat_cmplt_arbiter: directed vector table, async reset sequence,
// and a per-source in-order scoreboard under random load.
module tb_ct_mat_cmplt_arbiter;

    localparam int W = 7;

    logic         forever_cpuclk = 1'b0;
    logic         cpurst_b;
    logic         cp0_mat_icg_en, cp0_yy_clk_en, pad_yy_icg_scan_en;
    logic         rtu_yy_xx_flush;
    logic         cfg_sel, alu_sel, lsu_sel;
    logic [W-1:0] cfg_iid, alu_iid, lsu_iid;
    logic         cfg_full, alu_full, lsu_full;
    logic         cmplt;
    logic [W-1:0] iid;
    logic         idle, ovf;

    always #5 forever_cpuclk = ~forever_cpuclk;

    ct_mat_cmplt_arbiter #(.IID_W(W), .DEPTH(2)) dut (
        .forever_cpuclk             (forever_cpuclk),
        .cpurst_b                   (cpurst_b),
        .cp0_mat_icg_en             (cp0_mat_icg_en),
        .cp0_yy_clk_en              (cp0_yy_clk_en),
        .pad_yy_icg_scan_en         (pad_yy_icg_scan_en),
        .rtu_yy_xx_flush            (rtu_yy_xx_flush),
        .mat_cfg_cbus_ex1_pipe8_sel (cfg_sel),
        .mat_cfg_cbus_ex1_pipe8_iid (cfg_iid),
        .mat_alu_cbus_ex1_pipe8_sel (alu_sel),
        .mat_alu_cbus_ex1_pipe8_iid (alu_iid),
        .mat_lsu_cbus_ex1_pipe8_sel (lsu_sel),
        .mat_lsu_cbus_ex1_pipe8_iid (lsu_iid),
        .mat_cfg_cmplt_full         (cfg_full),
        .mat_alu_cmplt_full         (alu_full),
        .mat_lsu_cmplt_full         (lsu_full),
        .mat_rtu_pipe8_cmplt        (cmplt),
        .mat_rtu_pipe8_iid          (iid),
        .mat_cmplt_arb_idle         (idle),
        .mat_cmplt_ovf_err          (ovf)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]   sel;   // {lsu, alu, cfg}
        logic [W-1:0] c, a, l;
        logic         fl;
        logic         cm;
        logic [W-1:0] ei;
        logic [2:0]   ef;    // {lsu, alu, cfg}
        logic         eidle;
        logic         eovf;
    } vec_t;

    vec_t tbl[$];

    logic [W-1:0] q_cfg[$];
    logic [W-1:0] q_alu[$];
    logic [W-1:0] q_lsu[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ecm, input logic [W-1:0] ei,
                              input logic [2:0] ef, input logic eidle, input logic eovf);
        chk($sformatf("%s.cmplt", tag), 32'(cmplt), 32'(ecm));
        chk($sformatf("%s.iid", tag), 32'(iid), 32'(ei));
        chk($sformatf("%s.full", tag), 32'({lsu_full, alu_full, cfg_full}), 32'(ef));
        chk($sformatf("%s.idle", tag), 32'(idle), 32'(eidle));
        chk($sformatf("%s.ovf", tag), 32'(ovf), 32'(eovf));
    endtask

    task automatic addv(input logic [2:0] sel, input logic [W-1:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] l, input logic fl, input logic cm, input logic [W-1:0] ei,
                        input logic [2:0] ef, input logic eidle, input logic eovf);
        vec_t v;
        v.sel = sel; v.c = c; v.a = a; v.l = l; v.fl = fl;
        v.cm = cm; v.ei = ei; v.ef = ef; v.eidle = eidle; v.eovf = eovf;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [2:0] sel, input logic [W-1:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] l, input logic fl);
        cfg_sel = sel[0]; alu_sel = sel[1]; lsu_sel = sel[2];
        cfg_iid = c; alu_iid = a; lsu_iid = l;
        rtu_yy_xx_flush = fl;
    endtask

    // IID bits [6:5] carry the source index, so each completion is checked
    // against the oldest outstanding entry of that source
    task automatic sb_pop(input logic [W-1:0] got);
        case (got[6:5])
            2'd0: if (q_cfg.size() > 0) chk("sb.cfg", 32'(got), 32'(q_cfg.pop_front()));
                  else begin checks++; errors++; $display("FAIL sb.cfg: got %0h expected none", got); end
            2'd1: if (q_alu.size() > 0) chk("sb.alu", 32'(got), 32'(q_alu.pop_front()));
                  else begin checks++; errors++; $display("FAIL sb.alu: got %0h expected none", got); end
            2'd2: if (q_lsu.size() > 0) chk("sb.lsu", 32'(got), 32'(q_lsu.pop_front()));
                  else begin checks++; errors++; $display("FAIL sb.lsu: got %0h expected none", got); end
            default: begin checks++; errors++; $display("FAIL sb.src: got %0h expected source 0..2", got); end
        endcase
    endtask

    initial begin
        logic [4:0] seq0, seq1, seq2;
        logic       s0, s1, s2;

        // sel      cfg    alu    lsu    fl | cm  iid    full  idle ovf
        addv(3'b111, 7'h01, 7'h02, 7'h03, 0,  0, 7'h00, 3'b000, 1, 0); // three-way collision
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h01, 3'b000, 0, 0);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h02, 3'b000, 0, 0);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h03, 3'b000, 0, 0);
        addv(3'b010, 7'h00, 7'h15, 7'h00, 0,  0, 7'h00, 3'b000, 1, 0); // single alu
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h15, 3'b000, 0, 0);
        addv(3'b001, 7'h20, 7'h00, 7'h00, 0,  0, 7'h00, 3'b000, 1, 0); // fairness, cfg+lsu
        addv(3'b101, 7'h21, 7'h00, 7'h31, 0,  1, 7'h20, 3'b000, 0, 0);
        addv(3'b101, 7'h22, 7'h00, 7'h32, 0,  1, 7'h31, 3'b000, 0, 0);
        addv(3'b100, 7'h00, 7'h00, 7'h33, 0,  1, 7'h21, 3'b001, 0, 0);
        addv(3'b001, 7'h23, 7'h00, 7'h00, 0,  1, 7'h32, 3'b100, 0, 0);
        addv(3'b100, 7'h00, 7'h00, 7'h34, 0,  1, 7'h22, 3'b001, 0, 0);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h33, 3'b100, 0, 0);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h23, 3'b000, 0, 0);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h34, 3'b000, 0, 0);
        addv(3'b110, 7'h00, 7'h60, 7'h50, 0,  0, 7'h00, 3'b000, 1, 0); // cfg overflow
        addv(3'b101, 7'h41, 7'h00, 7'h51, 0,  1, 7'h60, 3'b000, 0, 0);
        addv(3'b001, 7'h42, 7'h00, 7'h00, 0,  1, 7'h50, 3'b100, 0, 0);
        addv(3'b101, 7'h43, 7'h00, 7'h52, 0,  1, 7'h41, 3'b001, 0, 0);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h51, 3'b100, 0, 1);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h42, 3'b000, 0, 1);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h52, 3'b000, 0, 1);
        addv(3'b011, 7'h30, 7'h70, 7'h00, 0,  0, 7'h00, 3'b000, 1, 1); // flush
        addv(3'b010, 7'h00, 7'h71, 7'h00, 0,  1, 7'h30, 3'b000, 0, 1);
        addv(3'b001, 7'h40, 7'h00, 7'h00, 1,  0, 7'h00, 3'b010, 0, 1);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  0, 7'h00, 3'b000, 1, 1);
        addv(3'b101, 7'h11, 7'h00, 7'h10, 0,  0, 7'h00, 3'b000, 1, 1); // rr_ptr kept across flush
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h10, 3'b000, 0, 1);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  1, 7'h11, 3'b000, 0, 1);
        addv(3'b000, 7'h00, 7'h00, 7'h00, 0,  0, 7'h00, 3'b000, 1, 1);

        cp0_mat_icg_en = 1'b0; cp0_yy_clk_en = 1'b1; pad_yy_icg_scan_en = 1'b0;
        drive(3'b000, '0, '0, '0, 1'b0);
        cpurst_b = 1'b0;
        #12;
        check_outs("reset", 1'b0, 7'h00, 3'b000, 1'b1, 1'b0);
        #1 cpurst_b = 1'b1;
        @(posedge forever_cpuclk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sel, tbl[i].c, tbl[i].a, tbl[i].l, tbl[i].fl);
            @(negedge forever_cpuclk);
            check_outs($sformatf("vec%0d", i), tbl[i].cm, tbl[i].ei, tbl[i].ef, tbl[i].eidle, tbl[i].eovf);
            @(posedge forever_cpuclk); #1;
        end

        // Async reset with four entries pending, asserted while the clock is high
        drive(3'b111, 7'h11, 7'h12, 7'h13, 1'b0);
        @(posedge forever_cpuclk); #1;
        drive(3'b011, 7'h14, 7'h15, 7'h00, 1'b0);
        @(posedge forever_cpuclk); #1;
        drive(3'b000, '0, '0, '0, 1'b0);
        #1;
        chk("arst.pre_idle", 32'(idle), 32'd0);
        chk("arst.pre_cmplt", 32'(cmplt), 32'd1);
        cpurst_b = 1'b0;
        #1;
        check_outs("arst", 1'b0, 7'h00, 3'b000, 1'b1, 1'b0);
        #3 cpurst_b = 1'b1;
        @(negedge forever_cpuclk);
        check_outs("arst.after", 1'b0, 7'h00, 3'b000, 1'b1, 1'b0);
        @(posedge forever_cpuclk); #1;

        // Random load, sources honour their full flags
        seq0 = '0; seq1 = '0; seq2 = '0;
        for (int c = 0; c < 300; c++) begin
            s0 = ($urandom_range(0, 99) < 60) && !cfg_full;
            s1 = ($urandom_range(0, 99) < 60) && !alu_full;
            s2 = ($urandom_range(0, 99) < 60) && !lsu_full;
            drive({s2, s1, s0}, {2'd0, seq0}, {2'd1, seq1}, {2'd2, seq2}, 1'b0);
            if (s0) begin q_cfg.push_back({2'd0, seq0}); seq0 = seq0 + 5'd1; end
            if (s1) begin q_alu.push_back({2'd1, seq1}); seq1 = seq1 + 5'd1; end
            if (s2) begin q_lsu.push_back({2'd2, seq2}); seq2 = seq2 + 5'd1; end
            @(negedge forever_cpuclk);
            if (cmplt) sb_pop(iid);
            @(posedge forever_cpuclk); #1;
        end
        drive(3'b000, '0, '0, '0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge forever_cpuclk);
            if (cmplt) sb_pop(iid);
            @(posedge forever_cpuclk); #1;
        end
        chk("sb.drained", 32'(q_cfg.size() + q_alu.size() + q_lsu.size()), 32'd0);
        chk("sb.idle", 32'(idle), 32'd1);
        chk("sb.ovf", 32'(ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
